axi_multiport_bridge: RTL

//  N-port SRAM-like to AXI3 bridge; successor of the fixed inst/data bridge in mycpu_top. Arbitrates NPORT

---
 rtl/axi_multiport_bridge.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_multiport_bridge.sv
// N-port SRAM-like to AXI3 bridge: round-robin arbitration, per-port
// outstanding read counters, one write in flight with read-after-write blocking.
module axi_multiport_bridge #(
    parameter int NPORT   = 2,
    parameter int RD_OUTS = 2
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [NPORT-1:0]    port_req,
    input  logic [NPORT-1:0]    port_wr,
    input  logic [2*NPORT-1:0]  port_size,
    input  logic [32*NPORT-1:0] port_addr,
    input  logic [4*NPORT-1:0]  port_wstrb,
    input  logic [32*NPORT-1:0] port_wdata,
    output logic [NPORT-1:0]    port_addr_ok,
    output logic [NPORT-1:0]    port_data_ok,
    output logic [32*NPORT-1:0] port_rdata,
    output logic                bus_err,
    output logic [3:0]          arid,
    output logic [31:0]         araddr,
    output logic [3:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [1:0]          arlock,
    output logic [3:0]          arcache,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,
    input  logic [3:0]          rid,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    output logic [3:0]          awid,
    output logic [31:0]         awaddr,
    output logic [3:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [1:0]          awlock,
    output logic [3:0]          awcache,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,
    output logic [3:0]          wid,
    output logic [31:0]         wdata,
    output logic [3:0]          wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [3:0]          bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);
    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

    typedef enum logic [1:0] {W_IDLE, W_AW_W, W_B} w_state_t;

    w_state_t         w_state, w_next;
    logic [PW-1:0]    rr, gnt_idx;
    logic [1:0]       w_owner;
    logic [2:0]       cnt [NPORT];
    logic [NPORT-1:0] elig, rd_grant, r_hit;
    logic             found, wr_grant, ar_free, wr_ok, r_acc;
    logic             b_done, collide, aw_done, w_done;
    logic [31:0]      g_addr;
    logic [1:0]       g_size;
    logic             unused;

    assign unused  = ^{rlast, bid, rid[3:2]};
    assign arlen   = 4'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awlen   = 4'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wlast   = 1'b1;
    assign awid    = {2'b00, w_owner};
    assign wid     = {2'b00, w_owner};

    assign ar_free = !arvalid || arready;
    assign wr_ok   = (w_state == W_IDLE);
    assign r_acc   = rvalid && rready;
    assign aw_done = !awvalid || awready;
    assign w_done  = !wvalid || wready;
    assign collide = rvalid && (rid[1:0] == w_owner);
    assign b_done  = bvalid && bready;

    // A read to the word held by the in-flight write must wait for its B.
    always_comb begin
        elig  = '0;
        r_hit = '0;
        for (int p = 0; p < NPORT; p++) begin
            elig[p] = port_req[p] && (port_wr[p] ? wr_ok :
                      (ar_free && (cnt[p] < 3'(RD_OUTS)) &&
                       !(!wr_ok && port_addr[32*p+2 +: 30] == awaddr[31:2])));
            r_hit[p] = r_acc && (rid[1:0] == 2'(p)) && (cnt[p] != 3'd0);
        end
    end

    always_comb begin
        port_addr_ok = '0;
        gnt_idx      = '0;
        found        = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            if (!found && elig[(int'(rr) + i) % NPORT]) begin
                found   = 1'b1;
                gnt_idx = PW'((int'(rr) + i) % NPORT);
            end
        end
        if (found) port_addr_ok[gnt_idx] = 1'b1;
    end

    assign wr_grant = found && port_wr[gnt_idx];
    assign rd_grant = port_addr_ok & ~port_wr;
    assign g_addr   = port_addr[32*gnt_idx +: 32];
    assign g_size   = port_size[2*gnt_idx +: 2];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE: if (wr_grant) w_next = W_AW_W;
            W_AW_W: if (aw_done && w_done) w_next = W_B;
            W_B:    if (b_done) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // A read beat for the write owner takes the data_ok slot first.
    always_comb begin
        bready = (w_state == W_B) && !collide;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arvalid <= 1'b0;
            araddr  <= '0;
            arsize  <= '0;
            arid    <= '0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            awaddr  <= '0;
            awsize  <= '0;
            w_owner <= '0;
            wdata   <= '0;
            wstrb   <= '0;
            rr      <= '0;
        end else begin
            if (found && !port_wr[gnt_idx]) begin
                arvalid <= 1'b1;
                araddr  <= g_addr;
                arsize  <= {1'b0, g_size};
                arid    <= {2'b00, 2'(gnt_idx)};
            end else if (arready) begin
                arvalid <= 1'b0;
            end
            if (w_state == W_IDLE && wr_grant) begin
                awvalid <= 1'b1;
                wvalid  <= 1'b1;
                awaddr  <= g_addr;
                awsize  <= {1'b0, g_size};
                w_owner <= 2'(gnt_idx);
                wdata   <= port_wdata[32*gnt_idx +: 32];
                wstrb   <= port_wstrb[4*gnt_idx +: 4];
            end else begin
                if (awready) awvalid <= 1'b0;
                if (wready)  wvalid  <= 1'b0;
            end
            if (found)
                rr <= (gnt_idx == PW'(NPORT - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rready       <= 1'b0;
            bus_err      <= 1'b0;
            port_data_ok <= '0;
            port_rdata   <= '0;
            for (int p = 0; p < NPORT; p++) cnt[p] <= 3'd0;
        end else begin
            rready <= 1'b1;
            if ((r_acc && rresp != 2'b00) || (b_done && bresp != 2'b00))
                bus_err <= 1'b1;
            for (int p = 0; p < NPORT; p++) begin
                cnt[p] <= cnt[p] + {2'b00, rd_grant[p]} - {2'b00, r_hit[p]};
                port_data_ok[p] <= r_hit[p] || (b_done && w_owner == 2'(p));
                if (r_hit[p]) port_rdata[32*p +: 32] <= rdata;
            end
        end
    end

endmodule
